// File: rtl/mod_ctrl_reg_loader.sv
// Control-register loader: writes a captured command descriptor to seven
// consecutive bus registers, reads them back, then launches and supervises one operation.
module mod_ctrl_reg_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h8000,
    parameter logic [15:0] TIMEOUT   = 16'd1000
) (
    input  logic        clk,
    input  logic        rst,
    // Command channel: a descriptor transfers on a rising clk edge where
    // cmdValid and cmdReady are both 1; cmdReady depends only on the FSM state.
    input  logic        cmdValid,
    output logic        cmdReady,
    input  logic [15:0] cmdOffset,
    input  logic [15:0] cmdDest,
    input  logic [15:0] cmdNumOps,
    input  logic [15:0] cmdIndexOffset,
    input  logic [15:0] cmdWeightOffset,
    input  logic [3:0]  cmdCacheCom,
    input  logic [6:0]  cmdControl,
    output logic        busWE,
    output logic [15:0] busAddr,
    output logic [15:0] busWData,
    input  logic [15:0] busRData,
    input  logic        critical,
    output logic        beginOp,
    input  logic        readyForNextOp,
    output logic        done,
    output logic        cfgErr,
    output logic        timeoutErr,
    output logic [2:0]  dbgState
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WRITE     = 3'd1;
    localparam logic [2:0] VERIFY    = 3'd2;
    localparam logic [2:0] ARM       = 3'd3;
    localparam logic [2:0] START     = 3'd4;
    localparam logic [2:0] WAIT_BUSY = 3'd5;
    localparam logic [2:0] WAIT_DONE = 3'd6;
    localparam logic [2:0] FIN       = 3'd7;

    localparam logic [2:0] LAST_IDX = 3'd6;

    logic [2:0]  state;
    logic [2:0]  idx;
    logic [15:0] cnt;
    logic        err;
    logic        tmo;

    logic [15:0] rOffset;
    logic [15:0] rDest;
    logic [15:0] rNumOps;
    logic [3:0]  rCacheCom;
    logic [6:0]  rControl;
    logic [15:0] rIndexOffset;
    logic [15:0] rWeightOffset;

    logic [15:0] fieldVal;
    logic [15:0] rdMasked;
    logic        mismatch;

    // Register order on the bus; narrow fields are zero-extended.
    always_comb begin
        fieldVal = 16'h0000;
        case (idx)
            3'd0:    fieldVal = rOffset;
            3'd1:    fieldVal = rDest;
            3'd2:    fieldVal = rNumOps;
            3'd3:    fieldVal = {12'h000, rCacheCom};
            3'd4:    fieldVal = {9'h000, rControl};
            3'd5:    fieldVal = rIndexOffset;
            3'd6:    fieldVal = rWeightOffset;
            default: fieldVal = 16'h0000;
        endcase
    end

    // Narrow registers may return junk in unimplemented upper bits.
    always_comb begin
        rdMasked = busRData;
        case (idx)
            3'd3:    rdMasked = busRData & 16'h000F;
            3'd4:    rdMasked = busRData & 16'h007F;
            default: rdMasked = busRData;
        endcase
    end

    assign mismatch = (rdMasked != fieldVal);

    always_comb begin
        cmdReady   = (state == IDLE);
        busWE      = (state == WRITE) && !critical;
        busAddr    = BASE_ADDR;
        busWData   = 16'h0000;
        if (state == WRITE) begin
            busAddr  = BASE_ADDR + {13'h0000, idx};
            busWData = fieldVal;
        end else if (state == VERIFY) begin
            busAddr  = BASE_ADDR + {13'h0000, idx};
        end
        beginOp    = (state == START);
        done       = (state == FIN);
        cfgErr     = (state == FIN) && err;
        timeoutErr = (state == FIN) && tmo;
        dbgState   = state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= 3'd0;
            cnt           <= 16'h0000;
            err           <= 1'b0;
            tmo           <= 1'b0;
            rOffset       <= 16'h0000;
            rDest         <= 16'h0000;
            rNumOps       <= 16'h0000;
            rCacheCom     <= 4'h0;
            rControl      <= 7'h00;
            rIndexOffset  <= 16'h0000;
            rWeightOffset <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (cmdValid) begin
                        rOffset       <= cmdOffset;
                        rDest         <= cmdDest;
                        rNumOps       <= cmdNumOps;
                        rCacheCom     <= cmdCacheCom;
                        rControl      <= cmdControl;
                        rIndexOffset  <= cmdIndexOffset;
                        rWeightOffset <= cmdWeightOffset;
                        idx           <= 3'd0;
                        state         <= WRITE;
                    end
                end
                WRITE: begin
                    // A busy target drops the write; hold the index and retry.
                    if (!critical) begin
                        if (idx == LAST_IDX) begin
                            idx   <= 3'd0;
                            state <= VERIFY;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                VERIFY: begin
                    if (mismatch) err <= 1'b1;
                    if (idx == LAST_IDX) begin
                        idx   <= 3'd0;
                        state <= (err || mismatch) ? FIN : ARM;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                ARM: begin
                    if (readyForNextOp) state <= START;
                end
                START: begin
                    cnt   <= 16'h0000;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // Target that never drops ready within two cycles finished already.
                    if (!readyForNextOp) begin
                        cnt   <= 16'h0000;
                        state <= WAIT_DONE;
                    end else if (cnt == 16'd1) begin
                        cnt   <= 16'h0000;
                        state <= FIN;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                WAIT_DONE: begin
                    if (readyForNextOp) begin
                        state <= FIN;
                    end else if (cnt == TIMEOUT - 16'd1) begin
                        tmo   <= 1'b1;
                        state <= FIN;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                FIN: begin
                    err   <= 1'b0;
                    tmo   <= 1'b0;
                    cnt   <= 16'h0000;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_ctrl_reg_loader.sv
// Directed bench for mod_ctrl_reg_loader: a register-file and target model
// around the loader, with one task per scenario and hand-computed expectations.
module tb_mod_ctrl_reg_loader;

    logic        clk;
    logic        rst;
    logic        cmdValid;
    logic        cmdReady;
    logic [15:0] cmdOffset, cmdDest, cmdNumOps, cmdIndexOffset, cmdWeightOffset;
    logic [3:0]  cmdCacheCom;
    logic [6:0]  cmdControl;
    logic        busWE;
    logic [15:0] busAddr, busWData, busRData;
    logic        critical;
    logic        beginOp;
    logic        rdy = 1'b1;
    logic        done, cfgErr, timeoutErr;
    logic [2:0]  dbgState;

    int vecs = 0;
    int errs = 0;

    // Model state
    logic [15:0] regFile [0:7];
    logic [15:0] wrAddr[$];
    logic [15:0] wrData[$];
    int          wrCyc[$];
    logic [15:0] expQ[$];
    logic [15:0] expDataQ[$];
    int          cyc = 0;
    int          boCount = 0;
    int          boCyc = 0;
    int          doneCyc = 0;
    int          busyLen = 5;
    int          busyLeft = 0;
    bit          hang = 0;
    bit          corruptLow = 0;
    bit          corruptHigh = 0;
    logic        doneCfg, doneTmo;

    mod_ctrl_reg_loader #(.BASE_ADDR(16'h8000), .TIMEOUT(16'd16)) dut (
        .clk(clk), .rst(rst),
        .cmdValid(cmdValid), .cmdReady(cmdReady),
        .cmdOffset(cmdOffset), .cmdDest(cmdDest), .cmdNumOps(cmdNumOps),
        .cmdIndexOffset(cmdIndexOffset), .cmdWeightOffset(cmdWeightOffset),
        .cmdCacheCom(cmdCacheCom), .cmdControl(cmdControl),
        .busWE(busWE), .busAddr(busAddr), .busWData(busWData), .busRData(busRData),
        .critical(critical), .beginOp(beginOp), .readyForNextOp(rdy),
        .done(done), .cfgErr(cfgErr), .timeoutErr(timeoutErr), .dbgState(dbgState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational register-file readback with optional corruption.
    always_comb begin
        logic [15:0] off;
        off = busAddr - 16'h8000;
        busRData = (off < 16'd8) ? regFile[off[2:0]] : 16'h0000;
        if (corruptLow && busAddr == 16'h8004) busRData = busRData ^ 16'h0001;
        if (corruptHigh && (busAddr == 16'h8003 || busAddr == 16'h8004))
            busRData = busRData ^ 16'hF080;
    end

    // Bus/target model: samples on negedge, commits after the following posedge.
    always begin
        logic        sWe, sBo, rSamp;
        logic [15:0] sAddr, sData;
        @(negedge clk);
        cyc++;
        sWe = busWE; sAddr = busAddr; sData = busWData; sBo = beginOp;
        if (beginOp) begin boCount++; boCyc = cyc; end
        if (done) doneCyc = cyc;
        @(posedge clk);
        rSamp = rst;
        #1;
        if (sWe && !rSamp) begin
            wrAddr.push_back(sAddr);
            wrData.push_back(sData);
            wrCyc.push_back(cyc);
            regFile[sAddr[2:0]] = sData;
        end
        if (rSamp) begin
            rdy = 1'b1; busyLeft = 0;
        end else if (sBo) begin
            if (hang || busyLen > 0) begin rdy = 1'b0; busyLeft = busyLen; end
        end else if (!hang && busyLeft > 0) begin
            busyLeft--;
            if (busyLeft == 0) rdy = 1'b1;
        end else if (!hang) begin
            rdy = 1'b1;
        end
    end

    task automatic clearLogs();
        wrAddr.delete(); wrData.delete(); wrCyc.delete();
        expQ.delete(); expDataQ.delete();
        boCount = 0;
    endtask

    task automatic sendCmd(input logic [15:0] off, dst, nops, io, wo,
                           input logic [3:0] cc, input logic [6:0] ct);
        bit got;
        got = 0;
        @(posedge clk); #1;
        cmdOffset = off; cmdDest = dst; cmdNumOps = nops;
        cmdIndexOffset = io; cmdWeightOffset = wo;
        cmdCacheCom = cc; cmdControl = ct;
        cmdValid = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (cmdReady === 1'b1) begin got = 1; break; end
        end
        vecs++;
        if (!got) begin errs++; $display("FAIL cmd_accept: cmdReady never 1, want 1"); end
        @(posedge clk); #1;
        cmdValid = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        bit got;
        got = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin got = 1; doneCfg = cfgErr; doneTmo = timeoutErr; break; end
        end
        vecs++;
        if (!got) begin errs++; $display("FAIL done_wait: no done within %0d cycles", budget); end
        @(posedge clk); #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vecs++; if (cmdReady !== 1'b1) begin errs++; $display("FAIL rst_cmdReady: got %b want 1", cmdReady); end
        vecs++; if (busWE !== 1'b0) begin errs++; $display("FAIL rst_busWE: got %b want 0", busWE); end
        vecs++; if (beginOp !== 1'b0) begin errs++; $display("FAIL rst_beginOp: got %b want 0", beginOp); end
        vecs++; if (done !== 1'b0 || cfgErr !== 1'b0 || timeoutErr !== 1'b0) begin
            errs++; $display("FAIL rst_flags: got %b%b%b want 000", done, cfgErr, timeoutErr); end
        vecs++; if (busAddr !== 16'h8000) begin errs++; $display("FAIL rst_busAddr: got %h want 8000", busAddr); end
        vecs++; if (busWData !== 16'h0000) begin errs++; $display("FAIL rst_busWData: got %h want 0000", busWData); end
        vecs++; if (dbgState !== 3'd0) begin errs++; $display("FAIL rst_state: got %0d want 0", dbgState); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_nominal();
        clearLogs();
        busyLen = 5;
        for (int k = 0; k < 7; k++) expQ.push_back(16'h8000 + 16'(k));
        expDataQ = '{16'h0010, 16'h1234, 16'h0042, 16'h000C, 16'h005A, 16'h0ABC, 16'h0DEF};
        sendCmd(16'h0010, 16'h1234, 16'h0042, 16'h0ABC, 16'h0DEF, 4'hC, 7'h5A);
        waitDone(100);
        vecs++; if (wrAddr.size() != 7) begin errs++; $display("FAIL nom_wr_count: got %0d want 7", wrAddr.size()); end
        for (int k = 0; k < 7 && k < wrAddr.size(); k++) begin
            vecs++; if (wrAddr[k] !== expQ[k]) begin errs++; $display("FAIL nom_wr_addr%0d: got %h want %h", k, wrAddr[k], expQ[k]); end
            vecs++; if (wrData[k] !== expDataQ[k]) begin errs++; $display("FAIL nom_wr_data%0d: got %h want %h", k, wrData[k], expDataQ[k]); end
        end
        if (wrCyc.size() == 7) begin
            vecs++; if (wrCyc[6] - wrCyc[0] != 6) begin errs++; $display("FAIL nom_wr_burst: got span %0d want 6", wrCyc[6] - wrCyc[0]); end
            vecs++; if (boCyc - wrCyc[6] != 9) begin errs++; $display("FAIL nom_verify_len: got %0d want 9", boCyc - wrCyc[6]); end
        end
        vecs++; if (boCount != 1) begin errs++; $display("FAIL nom_beginOp: got %0d pulses want 1", boCount); end
        vecs++; if (doneCyc - boCyc != 7) begin errs++; $display("FAIL nom_done_lat: got %0d want 7", doneCyc - boCyc); end
        vecs++; if (doneCfg !== 1'b0 || doneTmo !== 1'b0) begin errs++; $display("FAIL nom_errs: got cfg=%b tmo=%b want 0 0", doneCfg, doneTmo); end
        @(negedge clk);
        vecs++; if (done !== 1'b0 || cmdReady !== 1'b1) begin errs++; $display("FAIL nom_after: got done=%b rdy=%b want 0 1", done, cmdReady); end
    endtask

    task automatic test_stall();
        clearLogs();
        busyLen = 5;
        sendCmd(16'h1111, 16'h2222, 16'h3333, 16'h6666, 16'h7777, 4'h4, 7'h55);
        @(posedge clk); #1;
        @(posedge clk); #1;
        critical = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vecs++; if (busWE !== 1'b0 || busAddr !== 16'h8002) begin
                errs++; $display("FAIL stall_hold%0d: got we=%b addr=%h want 0 8002", k, busWE, busAddr); end
            @(posedge clk); #1;
        end
        critical = 1'b0;
        @(negedge clk);
        vecs++; if (busWE !== 1'b1 || busAddr !== 16'h8002) begin
            errs++; $display("FAIL stall_release: got we=%b addr=%h want 1 8002", busWE, busAddr); end
        waitDone(100);
        vecs++; if (wrAddr.size() != 7) begin errs++; $display("FAIL stall_wr_count: got %0d want 7", wrAddr.size()); end
        for (int k = 0; k < 7 && k < wrAddr.size(); k++) begin
            vecs++; if (wrAddr[k] !== 16'h8000 + 16'(k)) begin errs++; $display("FAIL stall_addr%0d: got %h want %h", k, wrAddr[k], 16'h8000 + 16'(k)); end
        end
        if (wrCyc.size() == 7) begin
            vecs++; if (wrCyc[2] - wrCyc[1] != 4) begin errs++; $display("FAIL stall_gap: got %0d want 4", wrCyc[2] - wrCyc[1]); end
        end
        vecs++; if (doneCfg !== 1'b0 || boCount != 1) begin errs++; $display("FAIL stall_done: got cfg=%b bo=%0d want 0 1", doneCfg, boCount); end
    endtask

    task automatic test_mismatch();
        clearLogs();
        corruptLow = 1;
        sendCmd(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, 16'h0E0E, 4'h9, 7'h33);
        waitDone(100);
        corruptLow = 0;
        vecs++; if (doneCfg !== 1'b1) begin errs++; $display("FAIL mis_cfgErr: got %b want 1", doneCfg); end
        vecs++; if (doneTmo !== 1'b0) begin errs++; $display("FAIL mis_tmo: got %b want 0", doneTmo); end
        vecs++; if (boCount != 0) begin errs++; $display("FAIL mis_beginOp: got %0d want 0", boCount); end
    endtask

    task automatic test_mask();
        clearLogs();
        corruptHigh = 1;
        sendCmd(16'h5555, 16'h6666, 16'h7777, 16'h8888, 16'h9999, 4'hF, 7'h7F);
        waitDone(100);
        corruptHigh = 0;
        vecs++; if (doneCfg !== 1'b0) begin errs++; $display("FAIL mask_cfgErr: got %b want 0", doneCfg); end
        vecs++; if (boCount != 1) begin errs++; $display("FAIL mask_beginOp: got %0d want 1", boCount); end
    endtask

    task automatic test_timeout();
        clearLogs();
        hang = 1;
        sendCmd(16'h0001, 16'h0002, 16'h0003, 16'h0006, 16'h0007, 4'h1, 7'h01);
        waitDone(150);
        hang = 0;
        vecs++; if (doneTmo !== 1'b1) begin errs++; $display("FAIL tmo_flag: got %b want 1", doneTmo); end
        vecs++; if (doneCfg !== 1'b0) begin errs++; $display("FAIL tmo_cfg: got %b want 0", doneCfg); end
        vecs++; if (doneCyc - boCyc - 2 != 16) begin errs++; $display("FAIL tmo_len: got %0d want 16", doneCyc - boCyc - 2); end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_fast_op();
        clearLogs();
        busyLen = 0;
        sendCmd(16'h00F0, 16'h00F1, 16'h00F2, 16'h00F5, 16'h00F6, 4'h3, 7'h40);
        waitDone(100);
        busyLen = 5;
        vecs++; if (doneCyc - boCyc != 3) begin errs++; $display("FAIL fast_lat: got %0d want 3", doneCyc - boCyc); end
        vecs++; if (doneCfg !== 1'b0 || doneTmo !== 1'b0) begin errs++; $display("FAIL fast_errs: got cfg=%b tmo=%b want 0 0", doneCfg, doneTmo); end
    endtask

    task automatic test_reset_mid();
        bit hit;
        hit = 0;
        clearLogs();
        sendCmd(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hEEEE, 4'h2, 7'h22);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busWE === 1'b1 && busAddr === 16'h8003) begin hit = 1; break; end
        end
        vecs++; if (!hit) begin errs++; $display("FAIL rmid_reach: write to 8003 not seen, want seen"); end
        #1 rst = 1'b1;
        #1;
        vecs++; if (busWE !== 1'b0) begin errs++; $display("FAIL rmid_busWE: got %b want 0", busWE); end
        vecs++; if (cmdReady !== 1'b1) begin errs++; $display("FAIL rmid_cmdReady: got %b want 1", cmdReady); end
        vecs++; if (busAddr !== 16'h8000) begin errs++; $display("FAIL rmid_busAddr: got %h want 8000", busAddr); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        vecs++; if (wrAddr.size() != 3) begin errs++; $display("FAIL rmid_writes: got %0d want 3", wrAddr.size()); end
        vecs++; if (boCount != 0) begin errs++; $display("FAIL rmid_beginOp: got %0d want 0", boCount); end
        clearLogs();
        sendCmd(16'h0102, 16'h0304, 16'h0506, 16'h0B0C, 16'h0D0E, 4'h7, 7'h09);
        waitDone(100);
        vecs++; if (wrAddr.size() != 7) begin errs++; $display("FAIL rmid_reload_count: got %0d want 7", wrAddr.size()); end
        if (wrAddr.size() > 0) begin
            vecs++; if (wrAddr[0] !== 16'h8000) begin errs++; $display("FAIL rmid_reload_first: got %h want 8000", wrAddr[0]); end
        end
        vecs++; if (doneCfg !== 1'b0 || boCount != 1) begin errs++; $display("FAIL rmid_reload_done: got cfg=%b bo=%0d want 0 1", doneCfg, boCount); end
    endtask

    initial begin
        cmdValid = 1'b0; critical = 1'b0;
        cmdOffset = '0; cmdDest = '0; cmdNumOps = '0;
        cmdIndexOffset = '0; cmdWeightOffset = '0;
        cmdCacheCom = '0; cmdControl = '0;
        test_reset();
        test_nominal();
        test_stall();
        test_mismatch();
        test_mask();
        test_timeout();
        test_fast_op();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mod_ctrl_reg_loader.md
MOD_CTRL_REG_LOADER -- requirements
Module: mod_ctrl_reg_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'h8000, giving the address of the first control register.
REQ-002 SHALL have parameter TIMEOUT, default 16'd1000, giving the maximum number of WAIT_DONE cycles.
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk in 1: sole clock, rising edge.
- rst in 1: asynchronous, active-high reset.
- cmdValid in 1: command descriptor offered.
- cmdReady out 1: loader can accept a command.
- cmdOffset, cmdDest, cmdNumOps, cmdIndexOffset, cmdWeightOffset in 16 each: register values.
- cmdCacheCom in 4: cache communication field.
- cmdControl in 7: control field.
- busWE out 1: register-bus write enable.
- busAddr out 16: register-bus address.
- busWData out 16: register-bus write data.
- busRData in 16: register-bus read data, combinational from busAddr.
- critical in 1: target is busy and ignores writes.
- beginOp out 1: operation start pulse.
- readyForNextOp in 1: target is idle.
- done out 1: one-cycle completion pulse.
- cfgErr out 1: readback mismatch, valid with done.
- timeoutErr out 1: operation timeout, valid with done.

Function
REQ-004 SHALL implement states IDLE, WRITE, VERIFY, ARM, START, WAIT_BUSY, WAIT_DONE, FIN.
REQ-005 cmdReady SHALL be 1 only in IDLE.
- On cmdValid&cmdReady, all cmd* fields SHALL be captured.
- The FSM SHALL go to WRITE with index 0.
REQ-006 Register index i (0..6) SHALL map to address BASE_ADDR+i in this order: offset, dest, numOps, cacheCom, control, indexOffset, weightOffset.
- cacheCom SHALL be zero-extended from 4 bits.
- control SHALL be zero-extended from 7 bits.
REQ-007 In WRITE:
- busAddr=BASE_ADDR+i and busWData=captured field i.
- busWE=~critical.
- The index SHALL advance only in cycles where busWE=1.
- After the write at i=6, the FSM SHALL go to VERIFY with i=0.
REQ-008 In VERIFY:
- busWE=0 and busAddr=BASE_ADDR+i.
- busRData SHALL be compared each cycle with expected field i, masked to 4 bits for i=3 and to 7 bits for i=4.
- Any mismatch SHALL set an internal err flag.
- After i=6: err=1 SHALL go to FIN; otherwise ARM.
REQ-009 ARM SHALL wait until readyForNextOp=1, then go to START.
REQ-010 START SHALL assert beginOp for exactly one cycle, then go to WAIT_BUSY.
REQ-011 WAIT_BUSY SHALL go to WAIT_DONE when readyForNextOp=0.
- If readyForNextOp is still 1 after 2 cycles, the operation SHALL be treated as already complete and the FSM SHALL go to FIN.
REQ-012 WAIT_DONE SHALL go to FIN when readyForNextOp=1.
- A 16-bit counter SHALL start at 0 on entry to WAIT_DONE.
- When the counter reaches TIMEOUT-1 without readyForNextOp=1, the internal tmo flag SHALL be set and the FSM SHALL go to FIN.
REQ-013 FIN SHALL last one cycle.
- done=1, cfgErr=err, timeoutErr=tmo.
- err and tmo SHALL be cleared after FIN.
- The FSM SHALL then return to IDLE.
REQ-014 Outside FIN, done, cfgErr and timeoutErr SHALL be 0.
REQ-015 Outside WRITE, busWE SHALL be 0.
- Outside START, beginOp SHALL be 0.
REQ-016 In IDLE, ARM and the wait states, busAddr SHALL hold BASE_ADDR and busWData SHALL be 0.
REQ-017 cmdValid outside IDLE SHALL be ignored; the descriptor SHALL not be captured.
REQ-018 The critical input SHALL affect only WRITE; other states SHALL ignore it.

Reset
REQ-019 rst=1 SHALL asynchronously force:
- state IDLE, i=0, counter 0, err=0, tmo=0, all captured fields 0;
- busWE=0, beginOp=0, done=0, cfgErr=0, timeoutErr=0, busAddr=BASE_ADDR, busWData=0, cmdReady=1.
REQ-020 Reset asserted mid-WRITE or mid-WAIT_DONE SHALL abort without any further bus write or beginOp.

Verification
REQ-021 Nominal load: cmd offset=16'h0010, control=7'h5A, others distinct, with a model register file and critical=0.
- Response: 7 consecutive writes at 8000..8006, 7 reads, then ARM, beginOp one cycle.
- Model drops readyForNextOp for 5 cycles, then raises it: done with cfgErr=0 and timeoutErr=0.
REQ-022 Stall: critical=1 during the write to 0x8002 for 3 cycles.
- Response: busWE=0 and busAddr held at 0x8002 for 3 cycles; write completes on the 4th cycle.
- No address is skipped.
REQ-023 Mismatch: model corrupts readback of 0x8004.
- Response: no beginOp; done=1 with cfgErr=1.
REQ-024 Timeout: TIMEOUT=16; model drops readyForNextOp and never restores it.
- Response: done=1 with timeoutErr=1, 16 cycles after entering WAIT_DONE.
REQ-025 Reset mid-op: rst pulses during the write to 0x8003.
- Response: busWE=0 immediately; cmdReady=1; no beginOp.
- A new command after reset loads from 0x8000.
